// File: rtl/job_loader.sv
// job_loader: front-end for the three-lane nonce-search system.
//
// Takes a mining job as a byte stream (NBYTES block bytes, first byte is the
// MSB, then one target byte), holds the search system in reset while loading
// and for two flush cycles afterwards, releases it, and waits for either the
// search to finish or an optional run-cycle timeout. The result is offered on
// a valid/ready port. Every output comes straight from a flop.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   byte_in/valid/ready job stream input (valid/ready handshake)
//   abort               single-cycle cancel of the current job
//   data_out/target_out assembled block and target for the search system
//   sys_reset           synchronous reset driven into the search system
//   finished, nonce_in  completion flag and nonce from the search system
//   result_*            result port: nonce (0 on timeout) and timeout flag
//   busy                high while arming or running

module job_loader #(
  parameter int BYTE_W      = 8,   // width of one stream element
  parameter int NBYTES      = 12,  // block bytes per job
  parameter int TO_W        = 24,  // run-cycle counter width
  parameter int TIMEOUT_MAX = 0    // run cycles before giving up, 0 = never
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BYTE_W-1:0]        byte_in,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  input  logic                     abort,
  output logic [BYTE_W*NBYTES-1:0] data_out,
  output logic [7:0]               target_out,
  output logic                     sys_reset,
  input  logic                     finished,
  input  logic [31:0]              nonce_in,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [31:0]              result_nonce,
  output logic                     result_timeout,
  output logic                     busy
);

  localparam int DATA_W = BYTE_W * NBYTES;
  localparam int CNT_W  = $clog2(NBYTES + 1);
  // Last run cycle before the timeout fires; only meaningful when enabled.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_MAX - 1);

  typedef enum logic [1:0] {LOAD, ARM, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  // Shared between ARM (flush length) and RUN (timeout); cleared on each entry.
  logic [TO_W-1:0]   run_cnt_q, run_cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [7:0]        target_q, target_d;
  logic              byte_ready_q, byte_ready_d;
  logic              sys_reset_q, sys_reset_d;
  logic              result_valid_q, result_valid_d;
  logic [31:0]       result_nonce_q, result_nonce_d;
  logic              result_timeout_q, result_timeout_d;
  logic              busy_q, busy_d;

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d          = state_q;
    byte_cnt_d       = byte_cnt_q;
    run_cnt_d        = run_cnt_q;
    data_d           = data_q;
    target_d         = target_q;
    result_valid_d   = result_valid_q;
    result_nonce_d   = result_nonce_q;
    result_timeout_d = result_timeout_q;

    unique case (state_q)
      LOAD: begin
        if (abort) begin
          // Restart the job; a byte offered in the same cycle is dropped.
          byte_cnt_d = '0;
        end else if (byte_valid && byte_ready_q) begin
          if (byte_cnt_q == CNT_W'(NBYTES)) begin
            target_d   = 8'(byte_in);
            byte_cnt_d = '0;
            run_cnt_d  = '0;
            state_d    = ARM;
          end else begin
            // Byte k lands in slot NBYTES-1-k, so the first byte is the MSB.
            for (int k = 0; k < NBYTES; k++) begin
              if (byte_cnt_q == CNT_W'(k)) begin
                data_d[(NBYTES-k)*BYTE_W-1 -: BYTE_W] = byte_in;
              end
            end
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
        end
      end

      ARM: begin
        // Two cycles of sys_reset flush the search pipelines.
        if (abort) begin
          run_cnt_d = '0;
          state_d   = LOAD;
        end else if (run_cnt_q == TO_W'(1)) begin
          run_cnt_d = '0;
          state_d   = RUN;
        end else begin
          run_cnt_d = run_cnt_q + TO_W'(1);
        end
      end

      RUN: begin
        // Priority: abort, then finished, then timeout.
        if (abort) begin
          run_cnt_d = '0;
          state_d   = LOAD;
        end else if (finished) begin
          result_valid_d   = 1'b1;
          result_nonce_d   = nonce_in;
          result_timeout_d = 1'b0;
          state_d          = DONE;
        end else if (TIMEOUT_MAX != 0 && run_cnt_q == TO_LAST) begin
          result_valid_d   = 1'b1;
          result_nonce_d   = '0;
          result_timeout_d = 1'b1;
          state_d          = DONE;
        end else if (run_cnt_q != '1) begin
          run_cnt_d = run_cnt_q + TO_W'(1);
        end
      end

      DONE: begin
        // result_valid_q is always set here; abort and finished are ignored.
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = LOAD;
        end
      end
    endcase

    // Status outputs are decoded from the next state so they line up with it.
    byte_ready_d = (state_d == LOAD);
    sys_reset_d  = (state_d != RUN);
    busy_d       = (state_d == ARM) || (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (reset) begin
      state_q          <= LOAD;
      byte_cnt_q       <= '0;
      run_cnt_q        <= '0;
      data_q           <= '0;
      target_q         <= '0;
      byte_ready_q     <= 1'b0;
      sys_reset_q      <= 1'b1;
      result_valid_q   <= 1'b0;
      result_nonce_q   <= '0;
      result_timeout_q <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      byte_cnt_q       <= byte_cnt_d;
      run_cnt_q        <= run_cnt_d;
      data_q           <= data_d;
      target_q         <= target_d;
      byte_ready_q     <= byte_ready_d;
      sys_reset_q      <= sys_reset_d;
      result_valid_q   <= result_valid_d;
      result_nonce_q   <= result_nonce_d;
      result_timeout_q <= result_timeout_d;
      busy_q           <= busy_d;
    end
  end

  assign byte_ready     = byte_ready_q;
  assign data_out       = data_q;
  assign target_out     = target_q;
  assign sys_reset      = sys_reset_q;
  assign result_valid   = result_valid_q;
  assign result_nonce   = result_nonce_q;
  assign result_timeout = result_timeout_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_job_loader.sv
// Testbench for job_loader: directed scenarios plus randomized jobs. Expected
// results are queued when a run is launched and popped by a separate monitor
// whenever the DUT completes a result handshake.

module tb_job_loader;

  localparam int TMAX = 16;

  typedef logic [7:0] job_t [13];
  typedef struct {
    logic [31:0] nonce;
    logic        timeout;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        abort;
  logic [95:0] data_out;
  logic [7:0]  target_out;
  logic        sys_reset;
  logic        finished;
  logic [31:0] nonce_in;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result_nonce;
  logic        result_timeout;
  logic        busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  job_loader #(.BYTE_W(8), .NBYTES(12), .TO_W(24), .TIMEOUT_MAX(TMAX)) dut (
    .clk(clk), .reset(reset),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .abort(abort), .data_out(data_out), .target_out(target_out),
    .sys_reset(sys_reset), .finished(finished), .nonce_in(nonce_in),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_nonce(result_nonce), .result_timeout(result_timeout), .busy(busy)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; afterwards we sit 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a result handshake seen here completes on the next edge.
  always @(negedge clk) begin
    if (!reset && result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", result_valid, 1'b0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("sb_nonce", result_nonce, e.nonce);
        check("sb_timeout", result_timeout, e.timeout);
      end
    end
  end

  function automatic logic [95:0] block_of(input job_t j);
    logic [95:0] v = '0;
    for (int i = 0; i < 12; i++) v = {v[87:0], j[i]};
    return v;
  endfunction

  // Transfer j[0..n-1]; gappy toggles byte_valid every cycle with junk data.
  task automatic send_bytes(input job_t j, input int n, input bit gappy);
    int  sent = 0;
    int  cyc  = 0;
    bit  ph   = 1'b1;
    bit  xfer;
    while (sent < n && cyc < 200) begin
      byte_valid = gappy ? ph : 1'b1;
      byte_in    = byte_valid ? j[sent] : 8'($urandom);
      xfer       = byte_valid && byte_ready;
      tick();
      if (xfer) sent++;
      ph = ~ph;
      cyc++;
    end
    byte_valid = 1'b0;
    byte_in    = 8'($urandom);
    check("load_budget", sent, n);
  endtask

  // Full load, then verify the capture and the two-cycle flush into RUN.
  task automatic load_job(input job_t j, input bit gappy);
    send_bytes(j, 13, gappy);
    check("data_out", data_out, block_of(j));
    check("target_out", target_out, j[12]);
    check("ready_low_after_load", byte_ready, 1'b0);
    check("arm1_sys_reset", sys_reset, 1'b1);
    check("arm1_busy", busy, 1'b1);
    tick();
    check("arm2_sys_reset", sys_reset, 1'b1);
    check("arm2_busy", busy, 1'b1);
    tick();
    check("run_sys_reset", sys_reset, 1'b0);
    check("run_busy", busy, 1'b1);
    check("run_data_stable", data_out, block_of(j));
  endtask

  // Called in RUN cycle 0. fin<0 means finished is never pulsed; abort_c<0
  // means no abort. Returns whether a result is pending.
  task automatic run_job(input int fin, input logic [31:0] nonce, input int abort_c,
                         output bit has_res, output res_t r);
    int  fin_eff = (fin >= 0 && fin < TMAX) ? fin : TMAX - 1;
    bit  hit     = (fin >= 0 && fin < TMAX);
    bit  aborted = (abort_c >= 0 && abort_c <= fin_eff);
    int  c = 0;
    has_res   = !aborted;
    r.nonce   = hit ? nonce : 32'd0;
    r.timeout = !hit;
    if (has_res) exp_q.push_back(r);
    while (c < 40) begin
      finished = (c == fin);
      nonce_in = (c == fin) ? nonce : $urandom;
      abort    = (c == abort_c);
      tick();
      finished = 1'b0;
      abort    = 1'b0;
      c++;
      if (result_valid || !busy) break;
    end
    if (aborted) begin
      check("abort_latency", c, abort_c + 1);
      check("abort_no_result", result_valid, 1'b0);
      check("abort_sys_reset", sys_reset, 1'b1);
      check("abort_ready", byte_ready, 1'b1);
    end else begin
      check("result_latency", c, fin_eff + 1);
      check("result_valid", result_valid, 1'b1);
      check("done_sys_reset", sys_reset, 1'b1);
      check("done_busy", busy, 1'b0);
    end
  endtask

  task automatic drain(input int hold, input res_t r);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", result_valid, 1'b1);
      check("hold_nonce", result_nonce, r.nonce);
      check("hold_timeout", result_timeout, r.timeout);
      abort    = 1'b1;  // ignored in DONE
      finished = 1'b1;
      nonce_in = $urandom;
      tick();
    end
    abort        = 1'b0;
    finished     = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("post_valid", result_valid, 1'b0);
    check("post_ready", byte_ready, 1'b1);
    check("post_nonce_kept", result_nonce, r.nonce);
  endtask

  task automatic check_reset_values();
    check("rst_byte_ready", byte_ready, 1'b0);
    check("rst_data_out", data_out, 96'd0);
    check("rst_target_out", target_out, 8'd0);
    check("rst_sys_reset", sys_reset, 1'b1);
    check("rst_result_valid", result_valid, 1'b0);
    check("rst_result_nonce", result_nonce, 32'd0);
    check("rst_result_timeout", result_timeout, 1'b0);
    check("rst_busy", busy, 1'b0);
  endtask

  initial begin
    job_t j;
    job_t seq;
    res_t r;
    bit   has;

    reset = 1'b1; byte_in = '0; byte_valid = 1'b0; abort = 1'b0;
    finished = 1'b0; nonce_in = '0; result_ready = 1'b0;
    for (int i = 0; i < 12; i++) seq[i] = 8'(i + 1);
    seq[12] = 8'h10;

    repeat (3) tick();
    check_reset_values();
    reset = 1'b0;
    check("ready_still_low", byte_ready, 1'b0);
    tick();
    check("ready_rises", byte_ready, 1'b1);

    // Back-to-back load, hit with a held result.
    load_job(seq, 1'b0);
    check("tp1_block", data_out, 96'h0102030405060708090A0B0C);
    run_job(4, 32'h00001234, -1, has, r);
    drain(5, r);

    // Gappy load of the same job, then timeout.
    load_job(seq, 1'b1);
    check("tp2_block", data_out, 96'h0102030405060708090A0B0C);
    run_job(-1, 32'h0, -1, has, r);
    check("tp4_timeout", result_timeout, 1'b1);
    drain(1, r);

    // Finished coincides with the last run cycle: finished wins.
    for (int i = 0; i < 13; i++) j[i] = 8'($urandom);
    load_job(j, 1'b0);
    run_job(TMAX - 1, 32'h0000CAFE, -1, has, r);
    check("tp4_hit_nonce", result_nonce, 32'h0000CAFE);
    drain(0, r);

    // Reset after 5 bytes, then a clean full load.
    for (int i = 0; i < 13; i++) j[i] = 8'($urandom);
    send_bytes(j, 5, 1'b0);
    reset = 1'b1;
    tick();
    check_reset_values();
    reset = 1'b0;
    tick();
    check("ready_after_midreset", byte_ready, 1'b1);
    load_job(seq, 1'b0);
    run_job(2, 32'h1, -1, has, r);
    drain(0, r);

    // Abort in RUN cycle 3, then finished while loading is ignored.
    load_job(seq, 1'b0);
    run_job(-1, 32'h0, 3, has, r);
    result_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      finished = 1'b1;
      nonce_in = $urandom;
      tick();
      check("load_ignores_finished", result_valid, 1'b0);
    end
    finished     = 1'b0;
    result_ready = 1'b0;

    // Abort in LOAD with a byte offered in the same cycle.
    for (int i = 0; i < 13; i++) j[i] = 8'($urandom);
    send_bytes(j, 4, 1'b0);
    abort = 1'b1; byte_valid = 1'b1; byte_in = 8'hEE;
    tick();
    abort = 1'b0; byte_valid = 1'b0;
    for (int i = 0; i < 13; i++) j[i] = 8'($urandom);
    load_job(j, 1'b0);
    run_job(0, 32'hA5A5_0001, -1, has, r);
    drain(0, r);

    // Randomized jobs.
    for (int t = 0; t < 20; t++) begin
      int fin;
      int ab;
      for (int i = 0; i < 13; i++) j[i] = 8'($urandom);
      load_job(j, 1'($urandom));
      fin = $urandom_range(0, 20);
      if (fin >= TMAX) fin = -1;
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : -1;
      run_job(fin, $urandom, ab, has, r);
      if (has) drain($urandom_range(0, 3), r);
    end

    tick();
    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/job_loader.md
Name: job_loader

Overview:
- Upstream front-end for the three-lane nonce-search system.
- Receives a mining job as a byte stream over a valid/ready handshake: 12 block bytes, then 1 target byte.
- Presents the assembled 96-bit block and 8-bit target to the search system and holds it in reset while loading.
- Releases the search, watches for its result with an optional timeout, and returns the found nonce (or a timeout) on a valid/ready result port.

Parameters:
byte, 8, bit width of one stream element
NBYTES, 12, block bytes per job (block width = byte*NBYTES)
TO_W, 24, width of run-cycle timeout counter
TIMEOUT_MAX, 0, run cycles before giving up; 0 disables timeout

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
byte_in  input  byte  job stream data
byte_valid  input  1  byte_in valid
byte_ready  output  1  loader accepts a byte this cycle
abort  input  1  cancel current job (single-cycle pulse)
data_out  output  byte*NBYTES  block to search system data_in
target_out  output  8  target to search system
sys_reset  output  1  synchronous reset driven into search system
finished  input  1  search system finished flag
nonce_in  input  32  search system nonce_out
result_valid  output  1  result available
result_ready  input  1  result consumer accepts
result_nonce  output  32  found nonce, 0 on timeout
result_timeout  output  1  result is a timeout, not a hit
busy  output  1  high in ARM or RUN

Behaviour:
- All outputs are registered.
- Reset values: byte_ready=0, data_out=0, target_out=0, sys_reset=1, result_valid=0, result_nonce=0, result_timeout=0, busy=0.
- After reset, the FSM is in LOAD with the byte counter at 0. byte_ready rises the cycle after reset falls.
- States: LOAD, ARM, RUN, DONE.
- LOAD:
  - byte_ready=1 and sys_reset=1.
  - A transfer occurs when byte_valid&&byte_ready.
  - Byte k (k=0..NBYTES-1) goes to data_out[(NBYTES-k)*byte-1 -: byte], so the first byte is the MSB.
  - Byte NBYTES goes to target_out.
  - Non-handshake cycles change nothing.
  - The cycle after the 13th transfer: state=ARM, byte_ready=0, counter cleared.
- ARM:
  - sys_reset stays 1 for exactly 2 cycles to flush the search pipelines; busy=1.
  - Then go to RUN, with sys_reset=0.
- RUN:
  - A run counter increments each cycle, starting at 0.
  - finished=1 sampled: next cycle state=DONE, result_nonce=nonce_in, result_timeout=0, result_valid=1, sys_reset=1.
  - If TIMEOUT_MAX!=0 and the counter equals TIMEOUT_MAX-1 with finished=0: next cycle state=DONE, result_nonce=0, result_timeout=1, result_valid=1, sys_reset=1.
  - If finished and the timeout coincide, finished wins.
  - The counter saturates and does not wrap.
- DONE:
  - result_* stay stable while result_ready=0.
  - On result_valid&&result_ready: next cycle result_valid=0, state=LOAD, byte_ready=1.
  - result_nonce and result_timeout keep their last values until the next result.
- data_out and target_out change only on LOAD transfers. They are stable through ARM, RUN and DONE.
- abort:
  - In ARM or RUN: next cycle state=LOAD, sys_reset=1, counter=0, no result is produced. data_out is kept and overwritten by the next load.
  - In LOAD: the byte counter clears, and any byte handshaking in the same cycle is discarded.
  - In DONE: ignored.
- reset in any state restores all reset values on the next edge, including mid-load and mid-run.
- finished is ignored outside RUN.

Test Plan:
1. Load bytes 0x01..0x0C, then target 0x10, all back-to-back -> data_out=0x0102030405060708090A0B0C, target_out=0x10; byte_ready low the cycle after the 13th byte; sys_reset high exactly 2 cycles, then 0; busy=1.
2. Same job with byte_valid toggled 1/0 every cycle -> only handshaken bytes are captured; identical data_out and target_out; exactly 13 transfers.
3. In RUN, pulse finished with nonce_in=0x00001234 -> next cycle result_valid=1, result_nonce=0x00001234, result_timeout=0, sys_reset=1. Hold result_ready=0 for 5 cycles -> outputs stable. Assert result_ready -> LOAD, byte_ready=1.
4. TIMEOUT_MAX=16, finished never asserted -> result_valid rises after 16 RUN cycles with result_timeout=1, result_nonce=0. Repeat with finished=1 (nonce 0xCAFE) on the 16th cycle -> result_nonce=0xCAFE, result_timeout=0.
5. Assert reset after 5 loaded bytes -> all outputs at reset values. A following full 13-byte load yields the correct data_out, with no leftover bytes.
6. abort in RUN cycle 3 -> next cycle LOAD, sys_reset=1, result_valid never asserted. A later finished pulse while in LOAD is ignored.
